// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire NRZ receiver.
// Recovers 24-bit pixel words from the LED data line. Each word is reported
// with its 0-based position in the frame. A long low period marks a frame
// boundary. The receiver stays silent until it has seen one full reset gap,
// so it never locks onto a frame part-way through.
//
// Pulse-width measurement: the cycle counter is cleared on every detected
// edge of the synchronized line. When the next edge is detected, the run
// that just ended lasted (cnt + 1) cycles. The thresholds below are
// therefore the parameter values minus one.

module ws2812_rx #(
    parameter int unsigned T_MIN_HIGH_CYC = 3,    // shorter high pulse is a glitch
    parameter int unsigned T_THRESH_CYC   = 10,   // high >= this decodes as '1'
    parameter int unsigned T_MAX_HIGH_CYC = 24,   // high reaching this is a stuck line
    parameter int unsigned T_RESET_CYC    = 800   // low this long ends a frame
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din,
    output logic [23:0] rgb_data,
    output logic [7:0]  led_num,
    output logic        valid,
    output logic        frame_done,
    output logic        error,
    output logic        busy
);

    localparam int unsigned CNT_W = $clog2(T_RESET_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LIM_GLITCH = CNT_W'(T_MIN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_ONE    = CNT_W'(T_THRESH_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_STUCK  = CNT_W'(T_MAX_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] LIM_GAP    = CNT_W'(T_RESET_CYC - 1);
    localparam logic [4:0]       LAST_BIT   = 5'd23;
    localparam logic [7:0]       IDX_SAT    = 8'hFF;

    typedef enum logic [1:0] {
        S_SYNC = 2'd0,   // waiting for a full reset gap before trusting the line
        S_IDLE = 2'd1,   // between frames, waiting for the first rising edge
        S_HIGH = 2'd2,   // measuring a high pulse
        S_LOW  = 2'd3    // measuring the low period after a bit
    } state_t;

    state_t state;
    state_t state_nxt;

    // Synchronizer and edge-detection pipeline.
    logic din_meta;
    logic din_s;
    logic din_d;
    logic rise;
    logic fall;

    // Datapath state.
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [23:0]      shift_q;
    logic [23:0]      shift_nxt;
    logic [4:0]       bit_cnt_q;
    logic [4:0]       bit_cnt_nxt;
    logic [7:0]       frame_idx_q;
    logic [7:0]       frame_idx_nxt;

    // Next values of the registered outputs.
    logic [23:0] rgb_nxt;
    logic [7:0]  led_nxt;
    logic        valid_nxt;
    logic        done_nxt;
    logic        error_nxt;
    logic        busy_nxt;

    // Line events, interpreted according to the state that is active.
    logic hi_stuck;
    logic hi_glitch;
    logic hi_one;
    logic lo_gap;

    assign rise      = din_s & ~din_d;
    assign fall      = ~din_s & din_d;
    assign hi_stuck  = (cnt >= LIM_STUCK);
    assign hi_glitch = fall && (cnt < LIM_GLITCH);
    assign hi_one    = (cnt >= LIM_ONE);
    assign lo_gap    = (cnt >= LIM_GAP);

    // Two-flop synchronizer for the asynchronous line, plus a one-cycle delay for edge detection
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples pre-edge values.
        if (reset) begin
            din_meta <= 1'b0;
            din_s    <= 1'b0;
            din_d    <= 1'b0;
        end else begin
            din_meta <= din;
            din_s    <= din_meta;
            din_d    <= din_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: errors fall back to SYNC, and a reset gap returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_SYNC: begin
                if (!din_s && lo_gap) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (rise) begin
                    state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (hi_stuck || hi_glitch) begin
                    state_nxt = S_SYNC;
                end else if (fall) begin
                    state_nxt = S_LOW;
                end
            end
            S_LOW: begin
                // A rise in the same cycle that completes the gap starts the next frame.
                if (lo_gap) begin
                    state_nxt = rise ? S_HIGH : S_IDLE;
                end else if (rise) begin
                    state_nxt = S_HIGH;
                end
            end
            default: begin
                state_nxt = S_SYNC;
            end
        endcase
    end

    // Output and datapath next values: bit shifting, word completion, frame end and error pulses
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path infers a latch.
        cnt_nxt       = (cnt == CNT_SAT) ? cnt : cnt + CNT_ONE;
        shift_nxt     = shift_q;
        bit_cnt_nxt   = bit_cnt_q;
        frame_idx_nxt = frame_idx_q;
        rgb_nxt       = rgb_data;
        led_nxt       = led_num;
        valid_nxt     = 1'b0;
        done_nxt      = 1'b0;
        error_nxt     = 1'b0;

        // Any edge restarts the measurement. While hunting for a gap, any high level restarts it too.
        if (rise || fall || (state == S_SYNC && din_s)) begin
            cnt_nxt = '0;
        end

        case (state)
            S_HIGH: begin
                if (hi_stuck || hi_glitch) begin
                    error_nxt     = 1'b1;
                    shift_nxt     = '0;
                    bit_cnt_nxt   = '0;
                    frame_idx_nxt = '0;
                end else if (fall) begin
                    shift_nxt = {shift_q[22:0], hi_one};
                    if (bit_cnt_q == LAST_BIT) begin
                        rgb_nxt     = shift_nxt;
                        led_nxt     = frame_idx_q;
                        valid_nxt   = 1'b1;
                        bit_cnt_nxt = '0;
                        if (frame_idx_q != IDX_SAT) begin
                            frame_idx_nxt = frame_idx_q + 8'd1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 5'd1;
                    end
                end
            end
            S_LOW: begin
                if (lo_gap) begin
                    done_nxt      = 1'b1;
                    error_nxt     = (bit_cnt_q != '0);
                    shift_nxt     = '0;
                    bit_cnt_nxt   = '0;
                    frame_idx_nxt = '0;
                end
            end
            default: begin
            end
        endcase

        busy_nxt = (state_nxt == S_HIGH) || (state_nxt == S_LOW);
    end

    // Datapath and output registers; pulses last exactly one cycle because their next value defaults to 0
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            frame_idx_q <= '0;
            rgb_data    <= '0;
            led_num     <= '0;
            valid       <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            shift_q     <= shift_nxt;
            bit_cnt_q   <= bit_cnt_nxt;
            frame_idx_q <= frame_idx_nxt;
            rgb_data    <= rgb_nxt;
            led_num     <= led_nxt;
            valid       <= valid_nxt;
            frame_done  <= done_nxt;
            error       <= error_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: self-checking bench for the WS2812 receiver.
// Expected words go into a scoreboard queue when they are driven onto the
// line. A monitor pops an entry and compares it on every valid pulse.
// Pulse counters track valid, frame_done and error for the per-scenario checks.

module tb_ws2812_rx;

    typedef struct packed {
        logic [23:0] rgb;
        logic [7:0]  led;
    } exp_t;

    typedef struct {
        logic [23:0] word;
        logic [7:0]  exp_led;
        bit          end_frame;
    } vec_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        din   = 1'b0;
    logic [23:0] rgb_data;
    logic [7:0]  led_num;
    logic        valid;
    logic        frame_done;
    logic        error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int n_valid    = 0;
    int n_done     = 0;
    int n_err      = 0;
    int n_done_err = 0;
    int n_both     = 0;
    int cyc        = 0;
    int err_cyc    = -1;

    int bv;
    int bd;
    int be;
    int bde;
    int rise_cyc;

    exp_t exp_q[$];
    vec_t vecs[12];

    ws2812_rx dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .rgb_data   (rgb_data),
        .led_num    (led_num),
        .valid      (valid),
        .frame_done (frame_done),
        .error      (error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (valid) begin
                n_valid++;
                check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_rgb_data", 32'(rgb_data), 32'(e.rgb));
                    check("sb_led_num", 32'(led_num), 32'(e.led));
                end
            end
            if (frame_done) n_done++;
            if (error) begin
                n_err++;
                err_cyc = cyc;
            end
            if (frame_done && error) n_done_err++;
            if (valid && error) n_both++;
        end
    end

    // All drive tasks start and end on a falling edge.
    task automatic level(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic raw_bit(input int hi, input int lo);
        level(1'b1, hi);
        level(1'b0, lo);
    endtask

    task automatic send_bit(input logic b);
        if (b) raw_bit(13, 7);
        else   raw_bit(6, 14);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic expect_word(input logic [23:0] w, input logic [7:0] l);
        exp_t e;
        e.rgb = w;
        e.led = l;
        exp_q.push_back(e);
    endtask

    task automatic snap();
        bv  = n_valid;
        bd  = n_done;
        be  = n_err;
        bde = n_done_err;
    endtask

    initial begin
        vecs[0]  = '{24'h7F0000, 8'd0, 1'b0};
        vecs[1]  = '{24'h007F00, 8'd1, 1'b0};
        vecs[2]  = '{24'h7F0000, 8'd2, 1'b0};
        vecs[3]  = '{24'h007F00, 8'd3, 1'b0};
        vecs[4]  = '{24'h7F0000, 8'd4, 1'b0};
        vecs[5]  = '{24'h007F00, 8'd5, 1'b0};
        vecs[6]  = '{24'h7F0000, 8'd6, 1'b0};
        vecs[7]  = '{24'h007F00, 8'd7, 1'b1};
        vecs[8]  = '{24'hFFFFFF, 8'd0, 1'b0};
        vecs[9]  = '{24'h000000, 8'd1, 1'b0};
        vecs[10] = '{24'hA5C33C, 8'd2, 1'b0};
        vecs[11] = '{24'h800001, 8'd3, 1'b1};

        @(negedge clk);

        // Reset state, then a single word after a full gap.
        reset = 1'b1;
        din   = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_rgb_data", 32'(rgb_data), 32'd0);
        check("rst_led_num", 32'(led_num), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        snap();
        level(1'b0, 800);
        check("t1_busy_before", 32'(busy), 32'd0);
        expect_word(24'h7F0000, 8'd0);
        send_word(24'h7F0000);
        level(1'b0, 20);
        check("t1_valid_count", 32'(n_valid - bv), 32'd1);
        check("t1_rgb_data", 32'(rgb_data), 32'h7F0000);
        check("t1_led_num", 32'(led_num), 32'd0);
        check("t1_busy_in_frame", 32'(busy), 32'd1);
        level(1'b0, 820);
        check("t1_done_count", 32'(n_done - bd), 32'd1);
        check("t1_err_count", 32'(n_err - be), 32'd0);
        check("t1_busy_after", 32'(busy), 32'd0);

        // Table-driven frames.
        snap();
        for (int i = 0; i < 12; i++) begin
            expect_word(vecs[i].word, vecs[i].exp_led);
            send_word(vecs[i].word);
            if (vecs[i].end_frame) begin
                level(1'b0, 820);
                check("tbl_busy_after_gap", 32'(busy), 32'd0);
                check("tbl_rgb_hold", 32'(rgb_data), 32'(vecs[i].word));
                check("tbl_led_hold", 32'(led_num), 32'(vecs[i].exp_led));
            end
        end
        check("tbl_valid_count", 32'(n_valid - bv), 32'd12);
        check("tbl_done_count", 32'(n_done - bd), 32'd2);
        check("tbl_err_count", 32'(n_err - be), 32'd0);
        check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);

        // Bits right after reset, with no gap, must be ignored.
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        snap();
        send_word(24'h123456);
        check("t3_busy_sync", 32'(busy), 32'd0);
        check("t3_no_valid", 32'(n_valid - bv), 32'd0);
        level(1'b0, 800);
        expect_word(24'h00FF00, 8'd0);
        send_word(24'h00FF00);
        level(1'b0, 820);
        check("t3_valid_count", 32'(n_valid - bv), 32'd1);
        check("t3_done_count", 32'(n_done - bd), 32'd1);
        check("t3_err_count", 32'(n_err - be), 32'd0);

        // A 2-cycle glitch in mid-word.
        snap();
        for (int i = 23; i >= 14; i--) send_bit(1'(i % 2));
        raw_bit(2, 14);
        for (int i = 13; i >= 0; i--) send_bit(1'(i % 3 == 0));
        level(1'b0, 820);
        check("t4_err_count", 32'(n_err - be), 32'd1);
        check("t4_no_valid", 32'(n_valid - bv), 32'd0);
        check("t4_no_done", 32'(n_done - bd), 32'd0);
        expect_word(24'h00007F, 8'd0);
        send_word(24'h00007F);
        level(1'b0, 820);
        check("t4_recover_valid", 32'(n_valid - bv), 32'd1);
        check("t4_recover_done", 32'(n_done - bd), 32'd1);

        // Stuck-high line, then a partial word cut by a gap.
        snap();
        rise_cyc = cyc;
        level(1'b1, 30);
        level(1'b0, 820);
        check("t5_stuck_err", 32'(n_err - be), 32'd1);
        check("t5_stuck_latency", 32'((err_cyc - rise_cyc >= 24) && (err_cyc - rise_cyc <= 28)), 32'd1);
        check("t5_stuck_no_done", 32'(n_done - bd), 32'd0);
        for (int i = 0; i < 12; i++) send_bit(1'(i % 2));
        level(1'b0, 820);
        check("t5_partial_err", 32'(n_err - be), 32'd2);
        check("t5_partial_done", 32'(n_done - bd), 32'd1);
        check("t5_done_err_same", 32'(n_done_err - bde), 32'd1);
        check("t5_no_valid", 32'(n_valid - bv), 32'd0);

        // Threshold boundaries: 9-cycle high is '0', 10-cycle high is '1'; a 799-cycle low keeps the word.
        snap();
        expect_word(24'h555555, 8'd0);
        for (int i = 0; i < 24; i++) begin
            raw_bit((i % 2 == 1) ? 10 : 9, (i == 11) ? 799 : 11);
        end
        level(1'b0, 820);
        check("t6_valid_count", 32'(n_valid - bv), 32'd1);
        check("t6_rgb_data", 32'(rgb_data), 32'h555555);
        check("t6_err_count", 32'(n_err - be), 32'd0);
        check("t6_done_count", 32'(n_done - bd), 32'd1);

        // Reset asserted mid-word clears everything, with no error or frame_done.
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        level(1'b1, 5);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_rst_rgb_data", 32'(rgb_data), 32'd0);
        check("t6_rst_led_num", 32'(led_num), 32'd0);
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_frame_done", 32'(frame_done), 32'd0);
        check("t6_rst_error", 32'(error), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        din   = 1'b0;
        snap();
        level(1'b0, 820);
        check("t6_post_rst_done", 32'(n_done - bd), 32'd0);
        check("t6_post_rst_err", 32'(n_err - be), 32'd0);
        expect_word(24'hC0FFEE, 8'd0);
        send_word(24'hC0FFEE);
        level(1'b0, 820);
        check("t6_post_rst_valid", 32'(n_valid - bv), 32'd1);
        check("t6_post_rst_frame", 32'(n_done - bd), 32'd1);

        check("final_sb_empty", 32'(exp_q.size()), 32'd0);
        check("valid_error_exclusive", 32'(n_both), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
